nrisc_ula_issue: RTL and testbench
==================================

NRISC_ULA_ISSUE -- requirements
Module: nrisc_ula_issue

Interface
REQ-001 Parameter TAM, default 16, data width of operands and result.
REQ-002 Parameter LAT, default 1, register stages inside the ULA (0 = combinational ULA, legal range 0..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_op  input  4  operation code, passed unchanged to ULA_ctrl.
REQ-008 req_a  input  TAM  first operand.
REQ-009 req_b  input  TAM  second operand.
REQ-010 ULA_A  output  TAM  registered operand A to ULA.
REQ-011 ULA_B  output  TAM  registered operand B to ULA.
REQ-012 ULA_ctrl  output  4  registered operation code to ULA.
REQ-013 ULA_OUT  input  TAM  ULA result.
REQ-014 ULA_flags  input  3  ULA flags.
REQ-015 res_valid  output  1  captured result available.
REQ-016 res_ready  input  1  consumer accepts result.
REQ-017 res_data  output  TAM  captured ULA_OUT.
REQ-018 res_flags  output  3  captured ULA_flags.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-021 req_ready SHALL be combinational: 1 in IDLE; 1 in RESP only when res_ready=1; 0 in WAIT.
REQ-022 Accept = req_valid and req_ready at a rising edge; on accept, ULA_A<=req_a, ULA_B<=req_b, ULA_ctrl<=req_op, cnt<=LAT, state<=WAIT.
REQ-023 ULA_A, ULA_B, ULA_ctrl SHALL change only on accept; they hold last issued values otherwise.
REQ-024 In WAIT with cnt!=0: cnt decrements by 1 per cycle; no other state change.
REQ-025 In WAIT with cnt==0: res_data<=ULA_OUT, res_flags<=ULA_flags, res_valid<=1, state<=RESP.
REQ-026 Latency: for accept at edge N, capture SHALL occur at edge N+1+LAT; res_valid high from edge N+1+LAT.
REQ-027 In RESP: res_data, res_flags, res_valid held stable until res_ready=1.
REQ-028 RESP with res_ready=1 and req_valid=0: res_valid<=0, state<=IDLE.
REQ-029 RESP with res_ready=1 and req_valid=1: result retired and new request accepted in the same edge (res_valid<=0, state<=WAIT); back-to-back throughput = one op per LAT+2 cycles.
REQ-030 req_valid in WAIT SHALL be ignored; request inputs are not sampled.
REQ-031 res_ready outside RESP SHALL have no effect.
REQ-032 res_data/res_flags SHALL retain last captured value after retirement until next capture.
REQ-033 cnt width SHALL be 3 bits; no wrap-around possible for legal LAT.

Reset
REQ-034 rst=1 SHALL immediately (without clock) force state=IDLE, cnt=0, ULA_A=0, ULA_B=0, ULA_ctrl=0, res_data=0, res_flags=0, res_valid=0; hence busy=0, req_ready=1.
REQ-035 Reset during WAIT or RESP SHALL discard the in-flight operation; no result is presented after rst deasserts.
REQ-036 First accept possible on the first rising edge after rst deasserts.

Verification (bench ULA model: LAT stages, ULA_OUT=A+B mod 2^TAM, flags={carry,zero,neg})
REQ-037 LAT=1, req_a=16'h0003, req_b=16'h0004, req_op=4'h0 accepted at edge N -> res_valid rises at edge N+2, res_data=16'h0007, res_flags=3'b000, busy=1 from N to retirement.
REQ-038 LAT=1, req_a=16'hFFFF, req_b=16'h0001 -> res_data=16'h0000, res_flags=3'b110; res_ready held 0 for 5 cycles -> outputs stable, req_ready=0 throughout.
REQ-039 LAT=0, two requests with req_valid and res_ready held 1 -> second accepted on the retirement edge of the first; res_valid pulses once per op, accept edges 2 cycles apart.
REQ-040 req_valid=1 with different operands during WAIT -> ULA_A/ULA_B unchanged, captured result matches first request only.
REQ-041 rst pulsed during WAIT (between edges) -> res_valid=0, busy=0, ULA_A=0 immediately; no res_valid after release until a new accept.
REQ-042 LAT=3, accept at edge N -> res_valid rises exactly at edge N+4, not earlier.

Source files
------------

// File: rtl/nrisc_ula_issue_if.sv
// Request / ULA / result signal bundle between the issue block and its neighbours.
// master drives requests, ULA results and res_ready; slave is the issue block.
interface nrisc_ula_issue_if #(
  parameter int TAM = 16
) ();
  logic           req_valid;
  logic           req_ready;
  logic [3:0]     req_op;
  logic [TAM-1:0] req_a;
  logic [TAM-1:0] req_b;
  logic [TAM-1:0] ULA_A;
  logic [TAM-1:0] ULA_B;
  logic [3:0]     ULA_ctrl;
  logic [TAM-1:0] ULA_OUT;
  logic [2:0]     ULA_flags;
  logic           res_valid;
  logic           res_ready;
  logic [TAM-1:0] res_data;
  logic [2:0]     res_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, ULA_OUT, ULA_flags, res_ready,
    input  req_ready, ULA_A, ULA_B, ULA_ctrl, res_valid, res_data, res_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, ULA_OUT, ULA_flags, res_ready,
    output req_ready, ULA_A, ULA_B, ULA_ctrl, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/nrisc_ula_issue.sv
// Issue controller for a fixed-latency ULA: registers operands, waits LAT cycles,
// captures the ULA result and holds it until the consumer takes it.
module nrisc_ula_issue #(
  parameter int TAM = 16,
  parameter int LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  nrisc_ula_issue_if.slave     bus,
  output logic                 busy
);

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [TAM-1:0] ula_a_q, ula_b_q;
  logic [3:0]     ula_ctrl_q;
  logic [TAM-1:0] res_data_q;
  logic [2:0]     res_flags_q;
  logic           res_valid_q, res_valid_d;

  logic req_ready;
  logic accept;
  logic capture;
  logic retire;
  logic cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = WAIT;
      WAIT:    if (cnt_zero) state_d = RESP;
      RESP:    if (retire)   state_d = accept ? WAIT : IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // req_ready in RESP follows res_ready so a retire and a new accept can share an edge.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      RESP:    req_ready = bus.res_ready;
      default: req_ready = 1'b0;
    endcase
    cnt_zero = (cnt_q == 3'd0);
    accept   = bus.req_valid & req_ready;
    capture  = (state_q == WAIT) & cnt_zero;
    retire   = (state_q == RESP) & bus.res_ready;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = LAT_CNT;
    end else if ((state_q == WAIT) && !cnt_zero) begin
      cnt_d = cnt_q - 3'd1;
    end

    res_valid_d = res_valid_q;
    if (capture) begin
      res_valid_d = 1'b1;
    end else if (retire) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 3'd0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_ctrl_q  <= 4'd0;
      res_data_q  <= '0;
      res_flags_q <= 3'd0;
      res_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      if (accept) begin
        ula_a_q    <= bus.req_a;
        ula_b_q    <= bus.req_b;
        ula_ctrl_q <= bus.req_op;
      end
      if (capture) begin
        res_data_q  <= bus.ULA_OUT;
        res_flags_q <= bus.ULA_flags;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.ULA_A     = ula_a_q;
  assign bus.ULA_B     = ula_b_q;
  assign bus.ULA_ctrl  = ula_ctrl_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;

endmodule

// File: tb/tb_nrisc_ula_issue.sv
// Bench for nrisc_ula_issue: three instances (LAT=1,0,3) each with an adder ULA model;
// expected results are queued at issue and checked by per-instance monitors on retirement.
module tb_nrisc_ula_issue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] d;
    logic [2:0]  f;
  } exp_t;
  exp_t exp_q[$];

  logic [2:0]        req_valid_s, res_ready_s;
  logic [2:0][15:0]  req_a_s, req_b_s;
  logic [2:0][3:0]   req_op_s;
  logic [2:0]        req_ready_s, res_valid_s, busy_s;
  logic [2:0][15:0]  ula_a_s, ula_b_s, res_data_s;
  logic [2:0][3:0]   ula_ctrl_s;
  logic [2:0][2:0]   res_flags_s;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = lat_of(gi);
    nrisc_ula_issue_if #(.TAM(16)) u_if ();
    logic [18:0] r0;
    logic [18:0] pipe_q [8];
    logic [18:0] ula_res;
    logic [16:0] sum;

    nrisc_ula_issue #(.TAM(16), .LAT(L)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (u_if),
      .busy (busy_s[gi])
    );

    assign sum = {1'b0, u_if.ULA_A} + {1'b0, u_if.ULA_B};
    assign r0  = {sum[15:0], sum[16], (sum[15:0] == 16'h0), sum[15]};
    always @(posedge clk) begin
      pipe_q[0] <= r0;
      for (int i = 1; i < 8; i++) pipe_q[i] <= pipe_q[i-1];
    end
    if (L == 0) begin : g_comb
      assign ula_res = r0;
    end else begin : g_pipe
      assign ula_res = pipe_q[L-1];
    end

    assign u_if.req_valid = req_valid_s[gi];
    assign u_if.req_a     = req_a_s[gi];
    assign u_if.req_b     = req_b_s[gi];
    assign u_if.req_op    = req_op_s[gi];
    assign u_if.res_ready = res_ready_s[gi];
    assign u_if.ULA_OUT   = ula_res[18:3];
    assign u_if.ULA_flags = ula_res[2:0];

    assign req_ready_s[gi] = u_if.req_ready;
    assign res_valid_s[gi] = u_if.res_valid;
    assign ula_a_s[gi]     = u_if.ULA_A;
    assign ula_b_s[gi]     = u_if.ULA_B;
    assign ula_ctrl_s[gi]  = u_if.ULA_ctrl;
    assign res_data_s[gi]  = u_if.res_data;
    assign res_flags_s[gi] = u_if.res_flags;

    always @(negedge clk) begin
      exp_t e;
      if (!rst && u_if.res_valid && u_if.res_ready) begin
        $display("xact inst=%0d lat=%0d data=%h flags=%b", gi, L, u_if.res_data, u_if.res_flags);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: inst %0d got data %h required no result", gi, u_if.res_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst",  32'(gi),             32'(e.k));
          check("sb_data",  32'(u_if.res_data),  32'(e.d));
          check("sb_flags", 32'(u_if.res_flags), 32'(e.f));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request on instance k for one edge; returns the accept edge number.
  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, output int n);
    req_a_s[k]     = a;
    req_b_s[k]     = b;
    req_op_s[k]    = op;
    req_valid_s[k] = 1'b1;
    tick();
    n = cyc;
    req_valid_s[k] = 1'b0;
    check("accept_A",    32'(ula_a_s[k]),    32'(a));
    check("accept_B",    32'(ula_b_s[k]),    32'(b));
    check("accept_ctrl", 32'(ula_ctrl_s[k]), 32'(op));
    check("accept_busy", 32'(busy_s[k]),     32'd1);
  endtask

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [15:0] ed, input logic [2:0] ef,
                        input int hold);
    int n;
    int m;
    logic busy_ok;
    issue(k, a, b, op, n);
    exp_q.push_back('{k: 2'(k), d: ed, f: ef});
    m = -100;
    busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy_s[k] !== 1'b1) busy_ok = 1'b0;
      tick();
      if (res_valid_s[k] === 1'b1) begin
        m = cyc;
        break;
      end
    end
    check("latency", 32'(m - n), 32'(1 + lat_of(k)));
    check("busy_wait", 32'(busy_ok), 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(res_valid_s[k]), 32'd1);
      check("hold_data",  32'(res_data_s[k]),  32'(ed));
      check("hold_flags", 32'(res_flags_s[k]), 32'(ef));
      check("hold_rdy",   32'(req_ready_s[k]), 32'd0);
    end
    res_ready_s[k] = 1'b1;
    tick();
    res_ready_s[k] = 1'b0;
    check("retire_valid", 32'(res_valid_s[k]), 32'd0);
    check("retire_busy",  32'(busy_s[k]),      32'd0);
    check("retire_data",  32'(res_data_s[k]),  32'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int n2;
    logic seen;
    rst         = 1'b1;
    req_valid_s = '0;
    res_ready_s = '0;
    req_a_s     = '0;
    req_b_s     = '0;
    req_op_s    = '0;

    // Reset state before any clock edge.
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_busy",   32'(busy_s[k]),      32'd0);
      check("rst_rdy",    32'(req_ready_s[k]), 32'd1);
      check("rst_valid",  32'(res_valid_s[k]), 32'd0);
      check("rst_A",      32'(ula_a_s[k]),     32'd0);
      check("rst_ctrl",   32'(ula_ctrl_s[k]),  32'd0);
      check("rst_data",   32'(res_data_s[k]),  32'd0);
      check("rst_flags",  32'(res_flags_s[k]), 32'd0);
    end
    tick();
    rst = 1'b0;

    // First edge after release accepts; 3+4 with LAT=1.
    run_op(0, 16'h0003, 16'h0004, 4'h0, 16'h0007, 3'b000, 0);
    // Overflow to zero, result held for 5 cycles.
    run_op(0, 16'hFFFF, 16'h0001, 4'h1, 16'h0000, 3'b110, 5);

    // res_ready while idle does nothing.
    res_ready_s[0] = 1'b1;
    tick();
    check("idle_rr_busy",  32'(busy_s[0]),      32'd0);
    check("idle_rr_valid", 32'(res_valid_s[0]), 32'd0);
    check("idle_rr_data",  32'(res_data_s[0]),  32'h0000);
    res_ready_s[0] = 1'b0;

    // New operands during WAIT are ignored.
    issue(0, 16'h1234, 16'h0101, 4'h2, n1);
    exp_q.push_back('{k: 2'd0, d: 16'h1335, f: 3'b000});
    req_a_s[0]     = 16'hAAAA;
    req_b_s[0]     = 16'h5555;
    req_valid_s[0] = 1'b1;
    tick();
    check("wait_ign_A", 32'(ula_a_s[0]), 32'h1234);
    check("wait_ign_B", 32'(ula_b_s[0]), 32'h0101);
    tick();
    req_valid_s[0] = 1'b0;
    check("wait_ign_valid", 32'(res_valid_s[0]), 32'd1);
    check("wait_ign_lat",   32'(cyc - n1),       32'd2);
    res_ready_s[0] = 1'b1;
    tick();
    res_ready_s[0] = 1'b0;
    check("wait_ign_A2", 32'(ula_a_s[0]), 32'h1234);

    // LAT=0 back-to-back with req_valid and res_ready held high.
    res_ready_s[1] = 1'b1;
    issue(1, 16'h0010, 16'h0020, 4'h3, n1);
    exp_q.push_back('{k: 2'd1, d: 16'h0030, f: 3'b000});
    req_a_s[1]     = 16'h8000;
    req_b_s[1]     = 16'h8000;
    req_op_s[1]    = 4'h4;
    req_valid_s[1] = 1'b1;
    exp_q.push_back('{k: 2'd1, d: 16'h0000, f: 3'b110});
    tick();
    check("b2b_valid1", 32'(res_valid_s[1]), 32'd1);
    tick();
    n2 = cyc;
    req_valid_s[1] = 1'b0;
    check("b2b_spacing", 32'(n2 - n1),       32'd2);
    check("b2b_A2",      32'(ula_a_s[1]),    32'h8000);
    check("b2b_gap",     32'(res_valid_s[1]), 32'd0);
    check("b2b_busy",    32'(busy_s[1]),      32'd1);
    tick();
    check("b2b_valid2", 32'(res_valid_s[1]), 32'd1);
    tick();
    res_ready_s[1] = 1'b0;
    check("b2b_end_valid", 32'(res_valid_s[1]), 32'd0);
    check("b2b_end_busy",  32'(busy_s[1]),      32'd0);

    // LAT=3: result exactly four edges after accept.
    run_op(2, 16'h7FFF, 16'h0001, 4'h5, 16'h8000, 3'b001, 0);

    // Reset between edges during WAIT drops the operation.
    issue(2, 16'h1111, 16'h2222, 4'h6, n1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(res_valid_s[2]), 32'd0);
    check("arst_busy",  32'(busy_s[2]),      32'd0);
    check("arst_A",     32'(ula_a_s[2]),     32'd0);
    check("arst_rdy",   32'(req_ready_s[2]), 32'd1);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid_s[2] !== 1'b0 || busy_s[2] !== 1'b0) seen = 1'b1;
    end
    check("arst_no_result", 32'(seen), 32'd0);
    run_op(2, 16'h0F0F, 16'hF0F0, 4'h7, 16'hFFFF, 3'b001, 0);

    tick();
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
